// File: rtl/a2d_rr_sequencer.sv
// Round-robin A2D sequencer: sweeps ch0/ch4/ch5 through the shared SPI master, two transactions per channel.
// Optional A2D_AVG_EN: each capture stores the average of the previous and new reading.
module a2d_rr_sequencer #(
    parameter int TMO_CYCLES = 2048,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        rr_done,
    output logic        tmo_err
);

    // state | meaning: IDLE wait request | CMD command wrt | WAIT1 await done | GAP SS_n idle | READ read-back wrt | WAIT2 await done, capture
    typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2} state_t;

    localparam int TW = ($clog2(TMO_CYCLES) + 1 > 12) ? $clog2(TMO_CYCLES) + 1 : 12;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic          pending;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic          start, cap_en, abort, fin;
    logic [11:0]   cap_val;
    logic          unused_rd;

    assign unused_rd = ^rd_data[15:12];
    assign wrt  = (state == CMD) || (state == READ);
    assign busy = (state != IDLE) || rr_done;

    function automatic logic [2:0] chnl_of(input logic [1:0] i);
        case (i)
            2'd0:    chnl_of = 3'd0;
            2'd1:    chnl_of = 3'd4;
            default: chnl_of = 3'd5;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        start     = 1'b0;
        cap_en    = 1'b0;
        abort     = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (nxt || pending) begin
                    state_nxt = CMD;
                    start     = 1'b1;
                end
            end
            CMD:   state_nxt = WAIT1;
            WAIT1: begin
                if (done) state_nxt = GAP;
                else if (tmo_cnt == TMO_LAST) abort = 1'b1;
            end
            GAP:   if (gap_cnt == '0) state_nxt = READ;
            READ:  state_nxt = WAIT2;
            WAIT2: begin
                if (done) begin
                    cap_en = 1'b1;
                    if (idx == 2'd2) begin
                        state_nxt = IDLE;
                        idx_nxt   = 2'd0;
                        fin       = 1'b1;
                    end else begin
                        state_nxt = CMD;
                        idx_nxt   = idx + 2'd1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 2'd0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            // A request arriving while a sweep runs (including its rr_done cycle) is remembered once
            if (abort || state == IDLE) pending <= 1'b0;
            else if (nxt)               pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= 16'h0000;
            tmo_cnt <= '0;
            gap_cnt <= GAP_LAST;
            lft_ld  <= 12'h000;
            rght_ld <= 12'h000;
            batt    <= 12'h000;
            rr_done <= 1'b0;
            tmo_err <= 1'b0;
        end else begin
            rr_done <= fin;
            if (state_nxt == CMD) cmd <= {2'b00, chnl_of(idx_nxt), 11'h000};
            if (wrt) tmo_cnt <= '0;
            else if (state == WAIT1 || state == WAIT2) tmo_cnt <= tmo_cnt + TW'(1);
            if (state != GAP) gap_cnt <= GAP_LAST;
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            if (start)      tmo_err <= 1'b0;
            else if (abort) tmo_err <= 1'b1;
            if (cap_en) begin
                case (idx)
                    2'd0:    lft_ld  <= cap_val;
                    2'd1:    rght_ld <= cap_val;
                    default: batt    <= cap_val;
                endcase
            end
        end
    end

`ifdef A2D_AVG_EN
    logic [2:0]  seen;
    logic [11:0] old_val;
    logic        first;

    always_comb begin
        old_val = batt;
        first   = !seen[2];
        case (idx)
            2'd0: begin old_val = lft_ld;  first = !seen[0]; end
            2'd1: begin old_val = rght_ld; first = !seen[1]; end
            default: begin old_val = batt; first = !seen[2]; end
        endcase
        cap_val = first ? rd_data[11:0]
                        : 12'(({1'b0, old_val} + {1'b0, rd_data[11:0]}) >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= 3'b000;
        end else if (cap_en) begin
            case (idx)
                2'd0:    seen[0] <= 1'b1;
                2'd1:    seen[1] <= 1'b1;
                default: seen[2] <= 1'b1;
            endcase
        end
    end
`else
    assign cap_val = rd_data[11:0];
`endif

endmodule

// File: tb/tb_a2d_rr_sequencer.sv
// Scoreboard bench for a2d_rr_sequencer: stimulus pushes expected cmd words and sweep results, a monitor pops them.
module tb_a2d_rr_sequencer;
    localparam int TMO     = 2048;
    localparam int GAPC    = 2;
    localparam int SPI_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n, nxt, wrt, done, busy, rr_done, tmo_err;
    logic [15:0] cmd, rd_data;
    logic [11:0] lft_ld, rght_ld, batt;

    int checks = 0, errors = 0;
    int cyc = 0, last_wrt_cyc = 0, prev_wrt_cyc = 0, wrt_cnt = 0, rr_cnt = 0;
    bit phase = 1'b0;
    logic [15:0] cmd_q[$];
    logic [35:0] res_q[$];
    logic [11:0] adc[3];
    logic [11:0] m_reg[3];
    bit          m_seen[3];
    int spur_ask = 0, spur_seen = 0, drop_ask = 0, drop_seen = 0;
    int stub_cnt = 0, ch4_n = 0;
    logic [11:0] stub_val = 12'h000;

    a2d_rr_sequencer #(.TMO_CYCLES(TMO), .GAP_CYCLES(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
        .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .busy(busy), .rr_done(rr_done), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every wrt pulse and every rr_done pulse consumes one scoreboard entry
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            phase = 1'b0;
        end else begin
            if (wrt === 1'b1) begin
                wrt_cnt++;
                last_wrt_cyc = cyc;
                chk("wrt_expected", 36'(cmd_q.size() != 0), 36'd1);
                if (cmd_q.size() != 0) chk("cmd", 36'(cmd), 36'(cmd_q.pop_front()));
                if (phase) chk("read_spacing", 36'(cyc - prev_wrt_cyc), 36'(SPI_LAT + GAPC + 1));
                prev_wrt_cyc = cyc;
                phase = !phase;
            end
            if (rr_done === 1'b1) begin
                rr_cnt++;
                chk("busy_at_rr_done", 36'(busy), 36'd1);
                chk("rr_done_expected", 36'(res_q.size() != 0), 36'd1);
                if (res_q.size() != 0) chk("results", {lft_ld, rght_ld, batt}, res_q.pop_front());
            end
        end
    end

    // SPI master stub: done SPI_LAT cycles after each wrt, optional suppression and spurious done
    initial begin
        done = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            if (!rst_n) begin
                stub_cnt = 0;
                ch4_n = 0;
            end else if (spur_ask != spur_seen) begin
                spur_seen++;
                done = 1'b1;
                rd_data = 16'h0ABC;
            end else if (wrt === 1'b1) begin
                stub_cnt = SPI_LAT;
                case (cmd[13:11])
                    3'd0:    stub_val = adc[0];
                    3'd4:    stub_val = adc[1];
                    default: stub_val = adc[2];
                endcase
                if (drop_ask != drop_seen && cmd == 16'h2000) begin
                    ch4_n++;
                    if (ch4_n == 2) begin
                        stub_cnt = 0;
                        ch4_n = 0;
                        drop_seen++;
                    end
                end
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    done = 1'b1;
                    rd_data = {4'hA, stub_val};
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        step();
        nxt = 1'b0;
    endtask

    function automatic void model_cap(input int i, input logic [11:0] v);
`ifdef A2D_AVG_EN
        if (m_seen[i]) m_reg[i] = 12'(({1'b0, m_reg[i]} + {1'b0, v}) >> 1);
        else           m_reg[i] = v;
`else
        m_reg[i] = v;
`endif
        m_seen[i] = 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_reg[i] = 12'h000;
            m_seen[i] = 1'b0;
        end
    endfunction

    task automatic expect_cmds(input int n);
        logic [15:0] seq[6];
        seq = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
        for (int i = 0; i < n; i++) cmd_q.push_back(seq[i]);
    endtask

    task automatic expect_sweep();
        expect_cmds(6);
        for (int i = 0; i < 3; i++) model_cap(i, adc[i]);
        res_q.push_back({m_reg[0], m_reg[1], m_reg[2]});
    endtask

    task automatic wait_rr(input int target);
        int n = 0;
        while (rr_cnt < target && n < 400) begin
            step();
            n++;
        end
        chk("rr_done_seen", 36'(rr_cnt >= target), 36'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        nxt = 1'b0;
        adc = '{12'h110, 12'h100, 12'hC00};
        model_reset();
        repeat (3) step();
        chk("reset_ctrl", 36'({wrt, busy, rr_done, tmo_err}), 36'd0);
        chk("reset_cmd", 36'(cmd), 36'd0);
        chk("reset_regs", {lft_ld, rght_ld, batt}, 36'd0);
        rst_n = 1'b1;
        repeat (2) step();

        spur_ask++;
        repeat (4) step();
        chk("idle_done_ignored", {wrt, busy, lft_ld, rght_ld, batt}, 36'd0);

        // Basic sweep
        expect_sweep();
        pulse_nxt();
        chk("wrt_latency", 36'({wrt, busy}), 36'b11);
        wait_rr(1);
        chk("busy_drop", 36'(busy), 36'd0);
        chk("sweep1_regs", {lft_ld, rght_ld, batt}, 36'h110100C00);

        // Three extra requests during a sweep collapse into one pending sweep
        expect_sweep();
        expect_sweep();
        pulse_nxt();
        repeat (5) step();
        pulse_nxt();
        repeat (8) step();
        pulse_nxt();
        repeat (8) step();
        pulse_nxt();
        wait_rr(2);
        chk("pending_no_dwell", 36'({wrt, busy}), 36'b11);
        wait_rr(3);
        chk("busy_after_pending", 36'(busy), 36'd0);
        repeat (60) step();
        chk("two_sweeps_only", 36'(rr_cnt), 36'd3);

        // New values, plus nxt coinciding with rr_done
        adc[0] = 12'h200;
        adc[1] = 12'h004;
        expect_sweep();
        expect_sweep();
        pulse_nxt();
        n = 0;
        while (rr_done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("rr_done_reached", 36'(rr_done), 36'd1);
        nxt = 1'b1;
        step();
        nxt = 1'b0;
        chk("nxt_with_rr_done", 36'({wrt, busy}), 36'b11);
        wait_rr(5);
        chk("sweep3_regs", {lft_ld, rght_ld, batt}, {m_reg[0], m_reg[1], m_reg[2]});

        // Timeout on the second ch4 transaction
        adc[0] = 12'h333;
        adc[1] = 12'h0AA;
        drop_ask++;
        expect_cmds(4);
        model_cap(0, adc[0]);
        pulse_nxt();
        n = 0;
        while (tmo_err !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk("tmo_err_set", 36'(tmo_err), 36'd1);
        chk("tmo_latency", 36'(cyc - last_wrt_cyc), 36'(TMO + 1));
        chk("tmo_busy", 36'({busy, rr_done}), 36'd0);
        chk("tmo_regs", {lft_ld, rght_ld, batt}, {m_reg[0], m_reg[1], m_reg[2]});
        adc[0] = 12'h123;
        expect_sweep();
        pulse_nxt();
        chk("tmo_err_clear", 36'(tmo_err), 36'd0);
        wait_rr(6);

        // Reset while waiting for the ch0 read-back
        expect_cmds(2);
        n = wrt_cnt + 2;
        pulse_nxt();
        while (wrt_cnt < n && cyc < 100000) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 36'({wrt, busy, rr_done, tmo_err}), 36'd0);
        chk("midrst_cmd", 36'(cmd), 36'd0);
        chk("midrst_regs", {lft_ld, rght_ld, batt}, 36'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        expect_sweep();
        pulse_nxt();
        chk("post_rst_cmd", 36'({wrt, cmd}), 36'h10000);
        wait_rr(7);

`ifdef A2D_AVG_EN
        adc[0] = 12'h100;
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        expect_sweep();
        pulse_nxt();
        wait_rr(8);
        chk("avg_first", 36'(lft_ld), 36'h100);
        adc[0] = 12'h200;
        expect_sweep();
        pulse_nxt();
        wait_rr(9);
        chk("avg_second", 36'(lft_ld), 36'h180);
`endif

        repeat (5) step();
        chk("cmd_q_empty", 36'(cmd_q.size()), 36'd0);
        chk("res_q_empty", 36'(res_q.size()), 36'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/a2d_rr_sequencer.md
Name: a2d_rr_sequencer

Overview:
- Sequences the shared SPI master toward the ADC128S A2D converter.
- Each request performs one round-robin sweep: left load cell (ch0), right load cell (ch4), battery (ch5), in that order.
- Each channel uses two 16-bit SPI transactions: command, then read-back. Results land in holding registers used by the steering-enable and battery-monitor logic.
- Sits between the Segway top level, the SPI master (wrt/done handshake) and the consumers of lft_ld/rght_ld/batt.

Parameters:
- TMO_CYCLES, 2048, clocks allowed from a wrt pulse to done before the sweep is aborted.
- GAP_CYCLES, 2, idle clocks inserted between the two transactions of a channel (SS_n deassert time).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- nxt  in  1  one-cycle request to start a sweep
- wrt  out  1  one-cycle pulse starting an SPI transaction
- cmd  out  16  SPI transmit word: {2'b00, chnl[2:0], 11'h000}
- done  in  1  SPI master transaction-complete pulse
- rd_data  in  16  SPI received word; result is rd_data[11:0]
- lft_ld  out  12  latest left load cell reading
- rght_ld  out  12  latest right load cell reading
- batt  out  12  latest battery reading
- busy  out  1  high from the cycle after an accepted nxt until the cycle after rr_done
- rr_done  out  1  one-cycle pulse when a full sweep completes
- tmo_err  out  1  sticky timeout flag

Behaviour:
- Reset values: wrt=0, cmd=0, lft_ld=0, rght_ld=0, batt=0, busy=0, rr_done=0, tmo_err=0. State=IDLE, channel index=0, pending=0.
- States: IDLE, CMD, WAIT1, GAP, READ, WAIT2.
- IDLE: nxt (or pending) -> CMD. tmo_err clears on an accepted nxt. Index=0 (ch0).
- Latency: nxt sampled at edge N -> wrt high during cycle N+1.
- CMD: wrt=1 for exactly one cycle. cmd = current channel command, held stable until next CMD. -> WAIT1.
- WAIT1: on done -> GAP.
- GAP: counts GAP_CYCLES -> READ.
- READ: wrt=1 for one cycle with the same cmd. -> WAIT2.
- WAIT2: on done, capture rd_data[11:0] into the register for the current index at that edge. Then:
  - index 0 -> 1 (ch4), back to CMD;
  - index 1 -> 2 (ch5), back to CMD;
  - index 2 -> IDLE, index wraps to 0, rr_done=1 in the same cycle batt shows its new value.
- Timeout: 12-bit-or-wider counter cleared on every wrt, increments in WAIT1/WAIT2. Reaching TMO_CYCLES-1 without done:
  - set tmo_err, go to IDLE, index=0, clear pending;
  - no rr_done; registers already captured in this sweep keep their new values, the others keep old values.
- nxt while busy: latched into a single pending bit (extra requests are dropped). Pending is serviced on the cycle after rr_done, with no IDLE dwell beyond one cycle.
- nxt in the same cycle as rr_done: treated as pending.
- done outside WAIT1/WAIT2: ignored.
- rd_data[15:12]: ignored.
- Reset asserted mid-sweep: immediate return to reset values. wrt drops asynchronously. No partial capture.

Optional Feature:
- Macro A2D_AVG_EN.
- Defined: each capture writes (old + new) >> 1, using a 13-bit sum with the LSB truncated. The first sweep after reset loads the raw value (per-register first-sample flag).
- Undefined: raw capture as above. No flag logic.

Test Plan:
- ADC model lft=0x110, rght=0x100, batt=0xC00; pulse nxt.
  - wrt pulses 6 times; cmd sequence 0x0000, 0x0000, 0x2000, 0x2000, 0x2800, 0x2800.
  - Results lft_ld=0x110, rght_ld=0x100, batt=0xC00; rr_done pulses once; busy drops one cycle later.
- nxt pulsed three times during a sweep -> exactly two sweeps total, two rr_done pulses.
- Change lft to 0x200, rght to 0x004, then nxt -> lft_ld=0x200, rght_ld=0x004, batt unchanged at 0xC00.
- SPI stub suppresses done on the second ch4 transaction:
  - after TMO_CYCLES, tmo_err=1, busy=0, no rr_done;
  - lft_ld shows the new value, rght_ld keeps its old value;
  - next nxt clears tmo_err.
- Assert rst_n low while in WAIT2 -> all outputs at reset values immediately; the next sweep starts cleanly at ch0.
- With A2D_AVG_EN: lft sweeps 0x100 then 0x200 -> lft_ld = 0x100 then 0x180.
